multdiv_ctrl: RTL
=================

MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT, 40, maximum BUSY cycles before a forced exception.
REQ-002 SHALL have port: clock  input  1  the single master clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req_mult  input  1  decoded mul instruction present in execute.
REQ-005 SHALL have port: req_div  input  1  decoded div instruction present in execute.
REQ-006 SHALL have port: op_a, op_b  input  32  regfile operands rs, rt.
REQ-007 SHALL have port: rd  input  5  destination register.
REQ-008 SHALL have port: ctrl_MULT, ctrl_DIV  output  1  start pulses to the multdiv unit.
REQ-009 SHALL have port: md_a, md_b  output  32  latched operands to the multdiv unit.
REQ-010 SHALL have port: md_result  input  32; md_exception  input  1; md_resultRDY  input  1.
REQ-011 SHALL have port: stall  output  1  hold the PC and the fetch stage.
REQ-012 SHALL have ports: wb_en  output  1; wb_reg  output  5; wb_data  output  32  regfile write-back request.

Function
REQ-013 SHALL implement the states IDLE, START, BUSY and WB.
REQ-014 In IDLE, when req_mult|req_div is high, SHALL latch op_a, op_b, rd and the operation, then go to START; mult SHALL win if both requests are high.
REQ-015 START SHALL assert exactly one of ctrl_MULT/ctrl_DIV for exactly one cycle, then go to BUSY.
REQ-016 BUSY SHALL wait for md_resultRDY, then capture md_result and md_exception and go to WB.
REQ-017 WB SHALL last exactly one cycle, then return to IDLE.
REQ-018 In WB with no exception, SHALL drive wb_en=1, wb_reg=rd and wb_data=result; if rd==0, wb_en SHALL be 0.
REQ-019 In WB with an exception, SHALL drive wb_en=1, wb_reg=30 and wb_data=4 (mult) or 5 (div).
REQ-020 stall SHALL be combinational and high in IDLE while a request is present, and in START and BUSY; it SHALL be low in WB.
REQ-021 Requests arriving outside IDLE SHALL be ignored; md_resultRDY outside BUSY SHALL be ignored.
REQ-022 md_a and md_b SHALL stay stable from START until leaving WB.
REQ-023 Latency from request to wb_en SHALL be 2 cycles plus the BUSY cycles, and the RDY cycle counts as BUSY.

Reset
REQ-024 reset SHALL force IDLE on the next clock edge and clear the latched operands, rd, result and counter to 0.
REQ-025 After reset, all outputs SHALL be 0, and stall SHALL be 0 unless a request is present.
REQ-026 Reset during BUSY SHALL abandon the operation, and no write-back SHALL follow.

Configuration
REQ-027 With MULTDIV_TIMEOUT_EN defined, SHALL count BUSY cycles; on reaching TIMEOUT without RDY, SHALL enter WB with an exception.
REQ-028 Without MULTDIV_TIMEOUT_EN, SHALL omit the counter and wait in BUSY indefinitely.

Structure
REQ-029 State encodings, RSTATUS_MULT=4, RSTATUS_DIV=5 and REG_RSTATUS=30 SHALL reside in the shared package multdiv_pkg.
REQ-030 The timeout counter SHALL be the sub-module md_timeout_cnt, instantiated only under MULTDIV_TIMEOUT_EN.

Verification
REQ-031 Bench SHALL cover: req_mult, op_a=5, op_b=3, rd=3, RDY+15 after 17 cycles -> single ctrl_MULT pulse in cycle 1; md_a=5, md_b=3; stall high cycles 0..18; wb_en with wb_reg=3, wb_data=15 in cycle 19 only.
REQ-032 Bench SHALL cover: req_div, op_a=7, op_b=0, rd=4, RDY+exception -> wb_reg=30, wb_data=5; no write to r4.
REQ-033 Bench SHALL cover: req_mult with rd=0, result 12 -> wb_en stays 0; stall drops in WB; next request is accepted.
REQ-034 Bench SHALL cover, with MULTDIV_TIMEOUT_EN and TIMEOUT=40: RDY never asserted -> WB after 40 BUSY cycles with wb_reg=30, wb_data=4; without the macro, stall remains high.
REQ-035 Bench SHALL cover: reset asserted in BUSY cycle 5, then RDY -> next cycle all outputs 0; no wb_en; later RDY ignored.
REQ-036 Bench SHALL cover: req_mult and req_div both high -> only ctrl_MULT pulses; the exception code used is 4.

Source files
------------

// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared state encoding and status constants for multdiv_ctrl
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        WB    = 2'd3
    } md_state_t;

    localparam logic [31:0] RSTATUS_MULT = 32'd4;
    localparam logic [31:0] RSTATUS_DIV  = 32'd5;
    localparam logic [4:0]  REG_RSTATUS  = 5'd30;

endpackage

// File: rtl/md_timeout_cnt.sv
// rtl/md_timeout_cnt.sv - BUSY-cycle counter, built only with MULTDIV_TIMEOUT_EN
module md_timeout_cnt #(
    parameter int TIMEOUT = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic busy,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count;

    // count holds the number of BUSY cycles already completed, so expiry fires in the last one
    always_ff @(posedge clock) begin
        if (reset || !busy) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = busy && (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - execute-stage sequencer for the iterative mult/div unit
// Optional BUSY timeout enabled by defining MULTDIV_TIMEOUT_EN.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_mult,
    input  logic        req_div,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  rd,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        stall,
    output logic        wb_en,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data
);

    md_state_t   state, state_next;
    logic [4:0]  lat_rd;
    logic        lat_div;
    logic [31:0] res_q;
    logic        exc_q;
    logic        timeout_hit;

`ifdef MULTDIV_TIMEOUT_EN
    md_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout_cnt (
        .clock  (clock),
        .reset  (reset),
        .busy   (state == BUSY),
        .expired(timeout_hit)
    );
`else
    // Never fires; TIMEOUT only matters when the counter is built.
    assign timeout_hit = (TIMEOUT < 0);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            md_a    <= '0;
            md_b    <= '0;
            lat_rd  <= '0;
            lat_div <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && (req_mult || req_div)) begin
                md_a    <= op_a;
                md_b    <= op_b;
                lat_rd  <= rd;
                lat_div <= !req_mult;
            end
            if (state == BUSY) begin
                if (md_resultRDY) begin
                    res_q <= md_result;
                    exc_q <= md_exception;
                end else if (timeout_hit) begin
                    res_q <= '0;
                    exc_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        ctrl_MULT  = 1'b0;
        ctrl_DIV   = 1'b0;
        stall      = 1'b0;
        wb_en      = 1'b0;
        wb_reg     = '0;
        wb_data    = '0;
        case (state)
            IDLE: begin
                stall = req_mult || req_div;
                if (req_mult || req_div) begin
                    state_next = START;
                end
            end
            START: begin
                stall      = 1'b1;
                ctrl_MULT  = !lat_div;
                ctrl_DIV   = lat_div;
                state_next = BUSY;
            end
            BUSY: begin
                stall = 1'b1;
                if (md_resultRDY || timeout_hit) begin
                    state_next = WB;
                end
            end
            WB: begin
                state_next = IDLE;
                // Exceptions report through the status register, even when rd is r0.
                if (exc_q) begin
                    wb_en   = 1'b1;
                    wb_reg  = REG_RSTATUS;
                    wb_data = lat_div ? RSTATUS_DIV : RSTATUS_MULT;
                end else begin
                    wb_en   = (lat_rd != 5'd0);
                    wb_reg  = lat_rd;
                    wb_data = res_q;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
